// File: rtl/ni_tdm_packetizer.sv
// TDM packetizer: buffers (address, data) pairs from the NI and injects each
// pair as a header/payload flit pair during this node's own TDM slot.
module ni_tdm_packetizer #(
    parameter int RSIZE     = 16,
    parameter int ADDRSIZE  = 2,
    parameter int SLOT_BITS = 3,
    parameter int SLOT_ID   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ni_write_en,
    input  logic [RSIZE-1:0]     ni_waddr,
    input  logic [RSIZE-1:0]     ni_wdata,
    output logic                 ni_wfull,
    output logic                 link_valid,
    output logic                 link_head,
    output logic [RSIZE-1:0]     link_flit,
    output logic [SLOT_BITS:0]   slot_cnt
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [SLOT_BITS-1:0] SLOT_ID_L  = SLOT_BITS'(SLOT_ID);
    localparam logic [SLOT_BITS:0]   SLOT_START = {SLOT_ID_L, 1'b0};
    localparam logic [SLOT_BITS:0]   SLOT_ONE   = (SLOT_BITS+1)'(1);
    localparam logic [ADDRSIZE-1:0]  PTR_ONE    = ADDRSIZE'(1);
    localparam logic [ADDRSIZE:0]    CNT_ONE    = (ADDRSIZE+1)'(1);
    localparam logic [ADDRSIZE:0]    CNT_FULL   = (ADDRSIZE+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD} state_t;

    logic [RSIZE-1:0] addr_mem [DEPTH];
    logic [RSIZE-1:0] data_mem [DEPTH];

    state_t               state_q, state_d;
    logic [SLOT_BITS:0]   slot_q;
    logic [ADDRSIZE-1:0]  wr_ptr_q, rd_ptr_q;
    logic [ADDRSIZE:0]    count_q, count_d;
    logic                 valid_q, valid_d;
    logic                 head_q, head_d;
    logic [RSIZE-1:0]     flit_q, flit_d;
    logic                 push, pop;

    // Full is judged on the registered count, so a push on the pop edge while full is refused.
    assign ni_wfull   = (count_q == CNT_FULL);
    assign push       = ni_write_en && !ni_wfull;
    assign link_valid = valid_q;
    assign link_head  = head_q;
    assign link_flit  = flit_q;
    assign slot_cnt   = slot_q;

    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        head_d  = 1'b0;
        flit_d  = '0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (slot_q == SLOT_START && count_q != '0) begin
                    state_d = HEAD;
                    valid_d = 1'b1;
                    head_d  = 1'b1;
                    flit_d  = addr_mem[rd_ptr_q];
                end
            end
            HEAD: begin
                state_d = PAYLOAD;
                valid_d = 1'b1;
                flit_d  = data_mem[rd_ptr_q];
                pop     = 1'b1;
            end
            PAYLOAD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= 1'b0;
            flit_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_q + SLOT_ONE;
            count_q <= count_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            flit_q  <= flit_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            addr_mem[wr_ptr_q] <= ni_waddr;
            data_mem[wr_ptr_q] <= ni_wdata;
        end
    end

endmodule

// File: tb/tb_ni_tdm_packetizer.sv
// Bench for ni_tdm_packetizer: directed table, corner sequences and random
// traffic checked against a queue-based slot-timing model.
module tb_ni_tdm_packetizer;

    localparam int RSIZE     = 16;
    localparam int ADDRSIZE  = 2;
    localparam int SLOT_BITS = 3;
    localparam int SLOT_ID   = 2;
    localparam int DEPTH     = 4;
    localparam int PERIOD    = 16;
    localparam int START     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              ni_write_en;
    logic [RSIZE-1:0]  ni_waddr, ni_wdata;
    logic              ni_wfull, link_valid, link_head;
    logic [RSIZE-1:0]  link_flit;
    logic [SLOT_BITS:0] slot_cnt;

    ni_tdm_packetizer #(
        .RSIZE(RSIZE), .ADDRSIZE(ADDRSIZE), .SLOT_BITS(SLOT_BITS), .SLOT_ID(SLOT_ID)
    ) dut (
        .clk(clk), .reset(reset), .ni_write_en(ni_write_en),
        .ni_waddr(ni_waddr), .ni_wdata(ni_wdata), .ni_wfull(ni_wfull),
        .link_valid(link_valid), .link_head(link_head),
        .link_flit(link_flit), .slot_cnt(slot_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] a; logic [15:0] d; } word_t;
    typedef struct {
        bit we; logic [15:0] a; logic [15:0] d;
        bit ev; bit eh; logic [15:0] ef; bit efull;
    } vec_t;

    // Reference model: packet queue plus slot arithmetic
    word_t       mq[$];
    int          m_slot;
    bit          m_send;
    bit          e_valid, e_head, e_full;
    logic [15:0] e_flit;

    logic [15:0] seen_hdr[$];
    logic [15:0] seen_pay[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit we, input logic [15:0] a, input logic [15:0] d);
        bit full_pre;
        word_t w;
        full_pre = (mq.size() == DEPTH);
        e_valid = 1'b0; e_head = 1'b0; e_flit = '0;
        if (m_slot == START && mq.size() != 0) begin
            m_send = 1'b1; e_valid = 1'b1; e_head = 1'b1; e_flit = mq[0].a;
        end else if (m_slot == START + 1 && m_send) begin
            m_send = 1'b0; e_valid = 1'b1; e_flit = mq[0].d;
            void'(mq.pop_front());
        end else begin
            m_send = 1'b0;
        end
        if (we && !full_pre) begin
            w.a = a; w.d = d;
            mq.push_back(w);
        end
        m_slot = (m_slot + 1) % PERIOD;
        e_full = (mq.size() == DEPTH);
    endtask

    task automatic compare_all();
        chk("slot_cnt",   32'(slot_cnt),   32'(m_slot));
        chk("link_valid", 32'(link_valid), 32'(e_valid));
        chk("link_head",  32'(link_head),  32'(e_head));
        chk("link_flit",  32'(link_flit),  32'(e_flit));
        chk("ni_wfull",   32'(ni_wfull),   32'(e_full));
        if (link_valid === 1'b1 && link_head === 1'b1) seen_hdr.push_back(link_flit);
        if (link_valid === 1'b1 && link_head === 1'b0) seen_pay.push_back(link_flit);
    endtask

    task automatic step(input bit we, input logic [15:0] a, input logic [15:0] d);
        ni_write_en = we; ni_waddr = a; ni_wdata = d;
        model_edge(we, a, d);
        @(posedge clk); #1;
        compare_all();
        ni_write_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; ni_write_en = 1'b0;
        mq.delete(); m_slot = 0; m_send = 1'b0;
        e_valid = 1'b0; e_head = 1'b0; e_flit = '0; e_full = 1'b0;
        @(posedge clk); #1;
        compare_all();
        reset = 1'b0;
    endtask

    task automatic goto_slot(input int s);
        int n = 0;
        while (m_slot != s && n < 40) begin
            step(1'b0, 16'h0, 16'h0);
            n++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0);
    endtask

    vec_t        tbl[10];
    logic [15:0] exp_a[$];
    logic [15:0] exp_d[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ni_write_en = 1'b0; ni_waddr = '0; ni_wdata = '0;
        for (int i = 0; i < 10; i++) tbl[i] = '{1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0};
        tbl[0] = '{1'b1, 16'hBCCB, 16'hABBA, 1'b0, 1'b0, 16'h0, 1'b0};
        tbl[4] = '{1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'hBCCB, 1'b0};
        tbl[5] = '{1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'hABBA, 1'b0};

        do_reset();

        // Single packet, table-driven
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].we, tbl[i].a, tbl[i].d);
            chk("tbl_valid", 32'(link_valid), 32'(tbl[i].ev));
            chk("tbl_head",  32'(link_head),  32'(tbl[i].eh));
            chk("tbl_flit",  32'(link_flit),  32'(tbl[i].ef));
            chk("tbl_full",  32'(ni_wfull),   32'(tbl[i].efull));
            $display("tbl[%0d] slot=%0d valid=%0b head=%0b flit=%h", i, slot_cnt, link_valid, link_head, link_flit);
        end
        idle(20);

        // Full: five pushes, the fifth is dropped
        goto_slot(8);
        seen_hdr.delete(); seen_pay.delete();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'hA000 + 16'(i), 16'hD000 + 16'(i));
            if (i == 3) chk("full_after_4th", 32'(ni_wfull), 32'd1);
            $display("full push %0d slot=%0d wfull=%0b", i, slot_cnt, ni_wfull);
        end
        idle(70);
        chk("full_pkt_count", 32'(seen_hdr.size()), 32'd4);
        chk("full_pay_count", 32'(seen_pay.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen_hdr.size() && i < seen_pay.size(); i++) begin
            chk("full_hdr_order", 32'(seen_hdr[i]), 32'(16'hA000 + 16'(i)));
            chk("full_pay_order", 32'(seen_pay[i]), 32'(16'hD000 + 16'(i)));
        end

        // Late arrival: push on the own-slot-start edge waits a full period
        goto_slot(START);
        begin
            int n = 0;
            step(1'b1, 16'h1111, 16'h2222);
            while (n < 40) begin
                step(1'b0, 16'h0, 16'h0);
                n++;
                if (link_valid === 1'b1 && link_head === 1'b1) break;
            end
            chk("late_latency", 32'(n), 32'd16);
            chk("late_flit", 32'(link_flit), 32'h1111);
            $display("late arrival header after %0d cycles slot=%0d", n, slot_cnt);
        end
        idle(4);

        // Push on the pop edge while full is refused
        goto_slot(0);
        seen_hdr.delete(); seen_pay.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 16'hC000 + 16'(i), 16'hE000 + 16'(i));
        step(1'b0, 16'h0, 16'h0);
        chk("pp_header_cycle", 32'(link_head & link_valid), 32'd1);
        step(1'b1, 16'hBAD0, 16'hBAD1);
        chk("pp_full_dropped", 32'(ni_wfull), 32'd0);
        step(1'b1, 16'h3333, 16'h4444);
        chk("pp_refill_full", 32'(ni_wfull), 32'd1);
        $display("push-on-pop: refill wfull=%0b slot=%0d", ni_wfull, slot_cnt);
        idle(80);
        chk("pp_pkt_count", 32'(seen_hdr.size()), 32'd5);
        if (seen_hdr.size() == 5) chk("pp_last_hdr", 32'(seen_hdr[4]), 32'h3333);

        // Reset during the header cycle aborts the packet
        goto_slot(0);
        step(1'b1, 16'h5555, 16'h6666);
        goto_slot(START + 1);
        chk("rst_hdr_present", 32'(link_head & link_valid), 32'd1);
        do_reset();
        chk("rst_valid", 32'(link_valid), 32'd0);
        chk("rst_slot",  32'(slot_cnt),   32'd0);
        chk("rst_full",  32'(ni_wfull),   32'd0);
        seen_hdr.delete(); seen_pay.delete();
        idle(40);
        chk("rst_no_payload", 32'(seen_pay.size()), 32'd0);
        chk("rst_no_header",  32'(seen_hdr.size()), 32'd0);
        $display("reset mid-packet: headers=%0d payloads=%0d", seen_hdr.size(), seen_pay.size());

        // Wrap-around: six packets, one per period
        seen_hdr.delete(); seen_pay.delete();
        exp_a.delete(); exp_d.delete();
        for (int k = 0; k < 6; k++) begin
            logic [15:0] a, d;
            a = {4'(k), 12'($urandom)};
            d = {4'(k + 8), 12'($urandom)};
            exp_a.push_back(a); exp_d.push_back(d);
            goto_slot(1);
            step(1'b1, a, d);
            $display("wrap push %0d addr=%h data=%h", k, a, d);
        end
        idle(20);
        chk("wrap_count", 32'(seen_hdr.size()), 32'd6);
        for (int k = 0; k < 6 && k < seen_hdr.size() && k < seen_pay.size(); k++) begin
            chk("wrap_hdr", 32'(seen_hdr[k]), 32'(exp_a[k]));
            chk("wrap_pay", 32'(seen_pay[k]), 32'(exp_d[k]));
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom));
        end
        $display("random phase done at slot=%0d", slot_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ni_tdm_packetizer.md
# ni_tdm_packetizer

Transmit-side stage directly downstream of the network interface (NI). It accepts (address, data) word pairs on the NI's write port, buffers them in a small FIFO, and injects each pair into the router link as a two-flit packet (header, payload). Injection happens only in this node's TDM slot, giving contention-free link access.

## Interface

Parameters:
- RSIZE, 16: width of address, data and link flit.
- ADDRSIZE, 2: FIFO pointer width; depth DEPTH = 1<<ADDRSIZE.
- SLOT_BITS, 3: TDM slot index width; 1<<SLOT_BITS slots per period, 2 cycles per slot.
- SLOT_ID, 0: slot owned by this node, range 0..(1<<SLOT_BITS)-1.

Ports:
- clk, in, 1: single clock, all state updates on rising edge.
- reset, in, 1: synchronous, active-high reset.
- ni_write_en, in, 1: NI push request.
- ni_waddr, in, RSIZE: destination address of the pushed word.
- ni_wdata, in, RSIZE: payload of the pushed word.
- ni_wfull, out, 1: FIFO full; a push is refused while high.
- link_valid, out, 1: link_flit carries a valid flit this cycle.
- link_head, out, 1: 1 = header flit (address), 0 = payload flit.
- link_flit, out, RSIZE: flit to router.
- slot_cnt, out, SLOT_BITS+1: free-running TDM cycle counter, for debug and bench alignment.

## Operation

- slot_cnt increments by 1 every cycle and wraps from 2^(SLOT_BITS+1)-1 to 0.
- Own-slot start: slot_cnt == {SLOT_ID, 1'b0}.
- FIFO: DEPTH entries of {addr, data}, with wr_ptr, rd_ptr and a count register of ADDRSIZE+1 bits. ni_wfull = (count == DEPTH), decoded from the registered count only.
- Push occurs when ni_write_en && !ni_wfull. A push while full is silently dropped; there is no retry.
- FSM states: IDLE, HEAD, PAYLOAD.
  - IDLE -> HEAD at the edge where slot_cnt is at own-slot start and count != 0. That edge registers link_valid=1, link_head=1, link_flit=addr[rd_ptr].
  - HEAD -> PAYLOAD at the next edge unconditionally. That edge registers link_valid=1, link_head=0, link_flit=data[rd_ptr], pops the entry (rd_ptr+1, count-1).
  - PAYLOAD -> IDLE at the next edge. That edge registers link_valid=0, link_head=0, link_flit=0.
- At most one packet per TDM period. Packets leave in FIFO order.
- Simultaneous push and pop on one edge: count is unchanged and both pointers advance. Full status is judged on the pre-edge count, so a push on the pop edge while full is refused.
- Pointers wrap modulo DEPTH naturally.

## Timing

- Reset values: slot_cnt=0, count=0, wr_ptr=rd_ptr=0, state IDLE, link_valid=0, link_head=0, link_flit=0, ni_wfull=0. FIFO contents are don't-care.
- Reset mid-packet aborts the packet. The next cycle shows link_valid=0, and all buffered entries are discarded.
- The FIFO is eligible for launch only if the entry was written at or before the edge preceding own-slot start. An entry written on the own-slot-start edge waits one full period.
- Link flits appear at slot_cnt = {SLOT_ID,1} (header) and {SLOT_ID,0}+2 (payload), modulo the period.
- ni_wfull rises in the cycle after the push that fills the FIFO. It falls in the cycle after the pop edge.
- Minimum push-to-header latency is 2 cycles; the maximum is 2^(SLOT_BITS+1)+1 cycles when the FIFO is otherwise empty.

## Test plan

The bench uses SLOT_BITS=3, SLOT_ID=2 and DEPTH=4. The period is 16 cycles and own-slot start is slot_cnt=4.

- Single packet: push (BCCB, ABBA) in cycle slot_cnt=0.
  - Required: header cycle slot_cnt=5 with link_valid=1, link_head=1, link_flit=BCCB.
  - Required: payload cycle slot_cnt=6 with link_head=0, link_flit=ABBA.
  - Required: link_valid=0 elsewhere and count=0 afterwards.
- Full: push 5 words on consecutive cycles starting at slot_cnt=8.
  - Required: ni_wfull=1 from the cycle after the 4th push, and the 5th push is dropped.
  - Required: 4 packets emerge in order over 4 periods. ni_wfull drops after the first payload edge.
- Late arrival: push on the edge where slot_cnt==4 with the FIFO empty. Required: no packet this period; the header appears 16 cycles later, at the next slot_cnt=5.
- Push-on-pop while full: with the FIFO full, assert ni_write_en during the cycle slot_cnt=5. Required: push refused, count=3 after the edge, and the following push accepted.
- Reset mid-packet: assert reset during the header cycle (slot_cnt=5). Required: next cycle link_valid=0, slot_cnt=0, ni_wfull=0, and no payload flit ever emitted.
- Wrap-around: 6 packets with distinct values, one pushed per period. Required: all 6 emerge in order with correct header/payload pairing across pointer wrap.
